// File: rtl/player_cannon.sv
// Player cannon: ship movement, NUM_SHOTS laser bank, lives and respawn/game-over FSM.
// Optional build macro PLAYER_CANNON_AUTOFIRE_EN adds periodic fire while btn_shoot is held.
module player_cannon #(
  parameter int COORD_W        = 11,
  parameter int SCREEN_W       = 640,
  parameter int SHIP_Y         = 425,
  parameter int SHIP_HALF_W    = 20,
  parameter int SHIP_HALF_H    = 5,
  parameter int SHOT_TOP       = 65,
  parameter int SHIP_STEP      = 1,
  parameter int SHOT_STEP      = 2,
  parameter int NUM_SHOTS      = 2,
  parameter int NUM_THREATS    = 6,
  parameter int LIVES_INIT     = 3,
  parameter int RESPAWN_FRAMES = 120
`ifdef PLAYER_CANNON_AUTOFIRE_EN
  , parameter int AUTOFIRE_FRAMES = 15
`endif
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           frame_tick,
  input  logic                           play_en,
  input  logic                           restart,
  input  logic                           btn_left,
  input  logic                           btn_right,
  input  logic                           btn_shoot,
  input  logic [NUM_THREATS*COORD_W-1:0] threat_x,
  input  logic [NUM_THREATS*COORD_W-1:0] threat_y,
  input  logic [NUM_THREATS-1:0]         threat_valid,
  input  logic [NUM_SHOTS-1:0]           shot_hit,
  input  logic [COORD_W-1:0]             pix_x,
  input  logic [COORD_W-1:0]             pix_y,
  output logic [COORD_W-1:0]             ship_x,
  output logic [NUM_SHOTS*COORD_W-1:0]   shot_x,
  output logic [NUM_SHOTS*COORD_W-1:0]   shot_y,
  output logic [NUM_SHOTS-1:0]           shot_active,
  output logic [2:0]                     lives,
  output logic                           game_over,
  output logic                           is_ship,
  output logic                           is_shot
);

  localparam int TW0     = $clog2(RESPAWN_FRAMES + 1);
  localparam int TIMER_W = (TW0 < 4) ? 4 : TW0;

  localparam logic [COORD_W-1:0] CENTER_X  = COORD_W'(SCREEN_W / 2);
  localparam logic [COORD_W-1:0] SPAWN_Y   = COORD_W'(SHIP_Y - SHIP_HALF_H - 3);
  localparam logic [COORD_W-1:0] RETIRE_Y  = COORD_W'(SHOT_TOP + SHOT_STEP);
  localparam logic [COORD_W-1:0] LEFT_LIM  = COORD_W'(SHIP_HALF_W);
  localparam logic [COORD_W-1:0] RIGHT_LIM = COORD_W'(SCREEN_W - SHIP_HALF_W);
  localparam logic [COORD_W-1:0] SHIP_YC   = COORD_W'(SHIP_Y);
  localparam logic [COORD_W-1:0] HALF_W    = COORD_W'(SHIP_HALF_W);
  localparam logic [COORD_W-1:0] HALF_H    = COORD_W'(SHIP_HALF_H);
  localparam logic [COORD_W-1:0] MOVE_STEP = COORD_W'(SHIP_STEP);
  localparam logic [COORD_W-1:0] FLY_STEP  = COORD_W'(SHOT_STEP);
  localparam logic [COORD_W:0]   HIT_TOP_W = (COORD_W+1)'(SHIP_Y - SHIP_HALF_H);
  localparam logic [COORD_W:0]   HALF_W_W  = (COORD_W+1)'(SHIP_HALF_W);

  typedef enum logic [1:0] {ALIVE, RESPAWN, DEAD} state_e;

  state_e               state_q, state_d;
  logic [COORD_W-1:0]   ship_x_q, ship_x_d;
  logic [COORD_W-1:0]   shot_x_q [NUM_SHOTS];
  logic [COORD_W-1:0]   shot_x_d [NUM_SHOTS];
  logic [COORD_W-1:0]   shot_y_q [NUM_SHOTS];
  logic [COORD_W-1:0]   shot_y_d [NUM_SHOTS];
  logic [NUM_SHOTS-1:0] shot_act_q, shot_act_d;
  logic [2:0]           lives_q, lives_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 btn_prev_q, btn_prev_d;
  logic                 tick;
  logic                 fire_req;
  logic                 ship_hit;

  assign tick = frame_tick & play_en;

`ifdef PLAYER_CANNON_AUTOFIRE_EN
  localparam int AF_W = $clog2(AUTOFIRE_FRAMES + 1);
  logic [AF_W-1:0] af_q, af_d;

  assign fire_req = btn_shoot & (~btn_prev_q | (af_q == AF_W'(AUTOFIRE_FRAMES - 1)));

  always_comb begin
    af_d = af_q;
    if (restart)
      af_d = '0;
    else if (tick)
      af_d = (!btn_shoot || fire_req) ? '0 : af_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) af_q <= '0;
    else     af_q <= af_d;
  end
`else
  assign fire_req = btn_shoot & ~btn_prev_q;
`endif

  // Widened compares so ship_x - SHIP_HALF_W cannot wrap near the left edge.
  always_comb begin
    ship_hit = 1'b0;
    for (int j = 0; j < NUM_THREATS; j++) begin
      if (threat_valid[j] &&
          {1'b0, threat_y[j*COORD_W +: COORD_W]} >= HIT_TOP_W &&
          {1'b0, threat_x[j*COORD_W +: COORD_W]} + HALF_W_W >= {1'b0, ship_x_q} &&
          {1'b0, threat_x[j*COORD_W +: COORD_W]} <= {1'b0, ship_x_q} + HALF_W_W)
        ship_hit = 1'b1;
    end
  end

  always_comb begin
    logic found;
    found      = 1'b0;
    state_d    = state_q;
    ship_x_d   = ship_x_q;
    shot_act_d = shot_act_q;
    lives_d    = lives_q;
    timer_d    = timer_q;
    btn_prev_d = btn_prev_q;
    for (int i = 0; i < NUM_SHOTS; i++) begin
      shot_x_d[i] = shot_x_q[i];
      shot_y_d[i] = shot_y_q[i];
    end

    if (restart) begin
      state_d    = ALIVE;
      ship_x_d   = CENTER_X;
      shot_act_d = '0;
      lives_d    = 3'(LIVES_INIT);
      timer_d    = '0;
      btn_prev_d = 1'b0;
      for (int i = 0; i < NUM_SHOTS; i++) begin
        shot_x_d[i] = CENTER_X;
        shot_y_d[i] = SPAWN_Y;
      end
    end else if (tick) begin
      btn_prev_d = btn_shoot;

      for (int i = 0; i < NUM_SHOTS; i++) begin
        if (shot_act_q[i]) begin
          if (shot_hit[i] || shot_y_q[i] <= RETIRE_Y) begin
            shot_act_d[i] = 1'b0;
            shot_y_d[i]   = SPAWN_Y;
          end else begin
            shot_y_d[i] = shot_y_q[i] - FLY_STEP;
          end
        end
      end

      // Slot choice looks at last tick's flags so a just-retired slot stays empty one tick.
      if (fire_req && state_q != DEAD) begin
        for (int i = 0; i < NUM_SHOTS; i++) begin
          if (!found && !shot_act_q[i]) begin
            found         = 1'b1;
            shot_act_d[i] = 1'b1;
            shot_x_d[i]   = ship_x_q;
            shot_y_d[i]   = SPAWN_Y;
          end
        end
      end

      if (state_q != DEAD) begin
        if (btn_left && !btn_right && ship_x_q > LEFT_LIM)
          ship_x_d = ship_x_q - MOVE_STEP;
        else if (btn_right && !btn_left && ship_x_q < RIGHT_LIM)
          ship_x_d = ship_x_q + MOVE_STEP;
      end

      case (state_q)
        ALIVE: begin
          if (ship_hit) begin
            if (lives_q > 3'd1) begin
              lives_d  = lives_q - 3'd1;
              ship_x_d = CENTER_X;
              timer_d  = TIMER_W'(RESPAWN_FRAMES);
              state_d  = RESPAWN;
            end else begin
              lives_d = 3'd0;
              state_d = DEAD;
            end
          end
        end
        RESPAWN: begin
          if (timer_q <= TIMER_W'(1)) begin
            timer_d = '0;
            state_d = ALIVE;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ALIVE;
      ship_x_q   <= CENTER_X;
      shot_act_q <= '0;
      lives_q    <= 3'(LIVES_INIT);
      timer_q    <= '0;
      btn_prev_q <= 1'b0;
      for (int i = 0; i < NUM_SHOTS; i++) begin
        shot_x_q[i] <= CENTER_X;
        shot_y_q[i] <= SPAWN_Y;
      end
    end else begin
      state_q    <= state_d;
      ship_x_q   <= ship_x_d;
      shot_act_q <= shot_act_d;
      lives_q    <= lives_d;
      timer_q    <= timer_d;
      btn_prev_q <= btn_prev_d;
      for (int i = 0; i < NUM_SHOTS; i++) begin
        shot_x_q[i] <= shot_x_d[i];
        shot_y_q[i] <= shot_y_d[i];
      end
    end
  end

  logic [COORD_W-1:0] ship_dx, ship_dy;
  logic               ship_box;
  logic [NUM_SHOTS-1:0] shot_pix;

  assign ship_dx  = (pix_x >= ship_x_q) ? pix_x - ship_x_q : ship_x_q - pix_x;
  assign ship_dy  = (pix_y >= SHIP_YC) ? pix_y - SHIP_YC : SHIP_YC - pix_y;
  assign ship_box = (ship_dx <= HALF_W) && (ship_dy <= HALF_H);

  // Bit 3 of the respawn timer gives an 8-frame on/off blink.
  assign is_ship = (state_q == ALIVE)   ? ship_box :
                   (state_q == RESPAWN) ? (ship_box & timer_q[3]) : 1'b0;

  for (genvar g = 0; g < NUM_SHOTS; g++) begin : g_shot
    logic [COORD_W-1:0] dx, dy;
    assign dx = (pix_x >= shot_x_q[g]) ? pix_x - shot_x_q[g] : shot_x_q[g] - pix_x;
    assign dy = (pix_y >= shot_y_q[g]) ? pix_y - shot_y_q[g] : shot_y_q[g] - pix_y;
    assign shot_pix[g] = shot_act_q[g] && (dx <= COORD_W'(1)) && (dy <= COORD_W'(5));
    assign shot_x[g*COORD_W +: COORD_W] = shot_x_q[g];
    assign shot_y[g*COORD_W +: COORD_W] = shot_y_q[g];
  end

  assign is_shot     = |shot_pix;
  assign ship_x      = ship_x_q;
  assign shot_active = shot_act_q;
  assign lives       = lives_q;
  assign game_over   = (state_q == DEAD);

endmodule
